// File: rtl/usb_string_streamer.sv
// rtl/usb_string_streamer.sv - GET_DESCRIPTOR(STRING) responder streaming descriptor bytes with packetisation and ZLP
module usb_string_streamer #(
    parameter int                      NUM_LANGS  = 1,
    parameter logic [NUM_LANGS*16-1:0] LANGIDS    = 16'h0409,
    parameter                          STRINGS    = {"Example Board", 8'h00, "ACME Systems", 8'h00},
    parameter int                      MAX_PACKET = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_index,
    input  logic [15:0] req_langid,
    input  logic [15:0] req_length,
    input  logic        abort,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        out_zlp,
    output logic        done,
    output logic        stall
);

    localparam int SB = $bits(STRINGS) / 8;
    localparam int PB = $clog2(MAX_PACKET);
    localparam int AW = (SB > 1) ? $clog2(SB) : 1;

    // mode 0: length of string n, mode 1: byte offset of string n, mode 2: string count
    function automatic int str_info(input int n, input int mode);
        int cur;
        int start;
        cur   = 0;
        start = 0;
        for (int k = 0; k < SB; k++) begin
            if (STRINGS[SB*8-1-8*k -: 8] == 8'h00) begin
                if (mode == 0 && cur == n) return k - start;
                if (mode == 1 && cur == n) return start;
                cur   = cur + 1;
                start = k + 1;
            end
        end
        return (mode == 2) ? cur : 0;
    endfunction

    localparam int NUM_STRS = str_info(0, 2);
    localparam int NS       = (NUM_STRS > 0) ? NUM_STRS : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_STREAM, S_ZLP} state_t;

    logic [7:0]    rom     [SB];
    logic [7:0]    len_tab [NS];
    logic [AW-1:0] off_tab [NS];

    for (genvar b = 0; b < SB; b++) begin : g_rom
        assign rom[b] = STRINGS[SB*8-1-8*b -: 8];
    end

    for (genvar g = 0; g < NS; g++) begin : g_str
        localparam int L = str_info(g, 0);
        localparam int O = str_info(g, 1);
        assign len_tab[g] = 8'(L);
        assign off_tab[g] = AW'(O);
    end

    state_t      state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] lang_q, lang_d;
    logic [15:0] len_q, len_d;
    logic        req_ready_q, req_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        out_zlp_q, out_zlp_d;
    logic        done_q, done_d;
    logic        stall_q, stall_d;

    logic          idx_ok;
    logic          lang_ok;
    logic [7:0]    str_len;
    logic [AW-1:0] str_off;
    logic [7:0]    desc_len;
    logic [7:0]    xfer_len;
    logic          zlp_needed;

    // Descriptor geometry depends only on the captured request, so it is valid through the whole transfer
    always_comb begin
        str_len = '0;
        str_off = '0;
        for (int n = 0; n < NS; n++) begin
            if (int'(idx_q) == n + 1) begin
                str_len = len_tab[n];
                str_off = off_tab[n];
            end
        end
        idx_ok  = int'(idx_q) <= NUM_STRS;
        lang_ok = 1'b0;
        for (int i = 0; i < NUM_LANGS; i++) begin
            if (lang_q == LANGIDS[(NUM_LANGS-1-i)*16 +: 16]) lang_ok = 1'b1;
        end
        desc_len   = (idx_q == 8'd0) ? 8'(2 + 2 * NUM_LANGS) : str_len + str_len + 8'd2;
        xfer_len   = ({8'h00, desc_len} <= len_q) ? desc_len : len_q[7:0];
        zlp_needed = (xfer_len[PB-1:0] == '0) && ({8'h00, xfer_len} < len_q);
    end

    logic [7:0]  nxt_pos;
    logic [7:0]  nxt_byte;
    logic [7:0]  k;
    logic [15:0] lw;
    logic        nxt_last;

    // Byte (and packet-end flag) for the position that will be presented after the next handshake
    always_comb begin
        nxt_pos = (state_q == S_LOOKUP) ? 8'd0 : pos_q + 8'd1;
        k       = nxt_pos - 8'd2;
        lw      = LANGIDS[NUM_LANGS*16-1 -: 16];
        for (int i = 0; i < NUM_LANGS; i++) begin
            if (int'(k[7:1]) == i) lw = LANGIDS[(NUM_LANGS-1-i)*16 +: 16];
        end
        if (nxt_pos == 8'd0) begin
            nxt_byte = desc_len;
        end else if (nxt_pos == 8'd1) begin
            nxt_byte = 8'h03;
        end else if (idx_q == 8'd0) begin
            nxt_byte = k[0] ? lw[15:8] : lw[7:0];
        end else begin
            nxt_byte = k[0] ? 8'h00 : rom[str_off + AW'(k[7:1])];
        end
        nxt_last = (&nxt_pos[PB-1:0]) || (nxt_pos == xfer_len - 8'd1);
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        idx_d       = idx_q;
        lang_d      = lang_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_zlp_d   = out_zlp_q;
        done_d      = 1'b0;
        stall_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    idx_d   = req_index;
                    lang_d  = req_langid;
                    len_d   = req_length;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!idx_ok || (idx_q != 8'd0 && !lang_ok)) begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end else if (xfer_len == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_STREAM;
                    pos_d       = nxt_pos;
                    out_valid_d = 1'b1;
                    out_data_d  = nxt_byte;
                    out_last_d  = nxt_last;
                    out_zlp_d   = 1'b0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (pos_q == xfer_len - 8'd1) begin
                        if (zlp_needed) begin
                            state_d    = S_ZLP;
                            out_data_d = 8'h00;
                            out_last_d = 1'b1;
                            out_zlp_d  = 1'b1;
                        end else begin
                            done_d      = 1'b1;
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                            out_data_d  = 8'h00;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        pos_d      = nxt_pos;
                        out_data_d = nxt_byte;
                        out_last_d = nxt_last;
                    end
                end
            end
            S_ZLP: begin
                if (out_ready) begin
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_zlp_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
            out_zlp_d   = 1'b0;
            done_d      = 1'b0;
            stall_d     = 1'b0;
        end
        // A rejected or empty request keeps req_ready low for one extra cycle after its pulse
        req_ready_d = (state_d == S_IDLE) && !(state_q == S_LOOKUP && !abort);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            idx_q       <= '0;
            lang_q      <= '0;
            len_q       <= '0;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_zlp_q   <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            idx_q       <= idx_d;
            lang_q      <= lang_d;
            len_q       <= len_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_zlp_q   <= out_zlp_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_zlp   = out_zlp_q;
    assign done      = done_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_usb_string_streamer.sv
// tb/tb_usb_string_streamer.sv - randomized reference-model bench for usb_string_streamer
module tb_usb_string_streamer;

    logic        clk;
    logic        reset_n    [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [7:0]  req_index  [2];
    logic [15:0] req_langid [2];
    logic [15:0] req_length [2];
    logic        abort      [2];
    logic [7:0]  out_data   [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic        out_last   [2];
    logic        out_zlp    [2];
    logic        done       [2];
    logic        stall      [2];

    int n_checks = 0;
    int n_fail   = 0;

    string       strs [2];
    logic [9:0]  exp_q [$];
    logic [9:0]  got_q [$];
    logic [7:0]  desc  [$];
    logic [15:0] langs [$];

    usb_string_streamer dut0 (
        .clk(clk), .reset_n(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_index(req_index[0]), .req_langid(req_langid[0]), .req_length(req_length[0]),
        .abort(abort[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .out_zlp(out_zlp[0]),
        .done(done[0]), .stall(stall[0])
    );

    usb_string_streamer #(
        .NUM_LANGS(3),
        .LANGIDS({16'h0409, 16'h0407, 16'h040C}),
        .MAX_PACKET(8)
    ) dut1 (
        .clk(clk), .reset_n(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_index(req_index[1]), .req_langid(req_langid[1]), .req_length(req_length[1]),
        .abort(abort[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .out_zlp(out_zlp[1]),
        .done(done[1]), .stall(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: kind 0 = data stream, 1 = stall, 2 = empty transfer
    task automatic build_exp(input int d, input int idx, input int lang, input int len, output int kind);
        int mp;
        int xfer;
        bit lok;
        string s;
        exp_q.delete();
        desc.delete();
        langs.delete();
        mp = (d == 0) ? 64 : 8;
        if (d == 0) langs.push_back(16'h0409);
        else begin
            langs.push_back(16'h0409);
            langs.push_back(16'h0407);
            langs.push_back(16'h040C);
        end
        lok = 0;
        foreach (langs[i]) if (int'(langs[i]) == lang) lok = 1;
        kind = 0;
        if (idx == 0) begin
            desc.push_back(8'(2 + 2 * langs.size()));
            desc.push_back(8'h03);
            foreach (langs[i]) begin
                desc.push_back(langs[i][7:0]);
                desc.push_back(langs[i][15:8]);
            end
        end else if (idx <= 2 && lok) begin
            s = strs[idx-1];
            desc.push_back(8'(2 + 2 * s.len()));
            desc.push_back(8'h03);
            for (int i = 0; i < s.len(); i++) begin
                desc.push_back(s[i]);
                desc.push_back(8'h00);
            end
        end else begin
            kind = 1;
        end
        if (kind == 0) begin
            xfer = (desc.size() < len) ? desc.size() : len;
            if (xfer == 0) kind = 2;
            for (int p = 0; p < xfer; p++)
                exp_q.push_back({1'b0, ((p + 1) % mp == 0) || (p == xfer - 1), desc[p]});
            if (xfer > 0 && xfer % mp == 0 && xfer < len) exp_q.push_back({1'b1, 1'b1, 8'h00});
        end
    endtask

    task automatic xfer(input int d, input int idx, input int lang, input int len,
                        input int rdy_pct, input int abort_at);
        int kind, cyc, last_hs, n;
        bit fin, hold, aborted, rdy;
        logic [9:0] hold_beat;
        build_exp(d, idx, lang, len, kind);
        got_q.delete();
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_before", req_ready[d], 1'b1);
        req_valid[d]  = 1'b1;
        req_index[d]  = 8'(idx);
        req_langid[d] = 16'(lang);
        req_length[d] = 16'(len);
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 1; last_hs = -10; fin = 0; hold = 0; aborted = 0; hold_beat = '0;
        while (!fin && cyc < 600) begin
            if (cyc == 1) begin
                check_eq("lookup_valid", out_valid[d], 1'b0);
                check_eq("lookup_ready", req_ready[d], 1'b0);
            end
            if (cyc == 2) begin
                check_eq("t2_valid", out_valid[d], kind == 0);
                check_eq("t2_stall", stall[d], kind == 1);
                check_eq("t2_done", done[d], kind == 2);
            end
            if (hold) begin
                check_eq("hold_valid", out_valid[d], 1'b1);
                check_eq("hold_beat", {out_zlp[d], out_last[d], out_data[d]}, hold_beat);
            end
            if (stall[d] || done[d]) begin
                fin = 1;
                if (kind == 0) begin
                    check_eq("done_ready", req_ready[d], 1'b1);
                    check_eq("done_timing", cyc, last_hs + 1);
                    check_eq("done_not_stall", stall[d], 1'b0);
                end else begin
                    check_eq("pulse_ready", req_ready[d], 1'b0);
                    @(negedge clk);
                    check_eq("t3_ready", req_ready[d], 1'b1);
                end
            end else begin
                hold = 0;
                if (out_valid[d] && abort_at >= 0 && got_q.size() == abort_at) begin
                    abort[d] = 1'b1;
                    out_ready[d] = 1'($urandom_range(1));
                    @(negedge clk);
                    abort[d] = 1'b0;
                    check_eq("abort_valid", out_valid[d], 1'b0);
                    check_eq("abort_ready", req_ready[d], 1'b1);
                    check_eq("abort_done", done[d], 1'b0);
                    @(negedge clk);
                    check_eq("abort_done2", done[d], 1'b0);
                    aborted = 1;
                    fin = 1;
                end else begin
                    rdy = ($urandom_range(99) < rdy_pct);
                    out_ready[d] = rdy;
                    if (out_valid[d]) begin
                        if (rdy) begin
                            got_q.push_back({out_zlp[d], out_last[d], out_data[d]});
                            last_hs = cyc;
                        end else begin
                            hold = 1;
                            hold_beat = {out_zlp[d], out_last[d], out_data[d]};
                        end
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        out_ready[d] = 1'b0;
        if (!fin) check_eq("timeout", 0, 1);
        if (!aborted) check_eq("beat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("beat_d%0d_i%0d_p%0d", d, idx, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int lang_tab [4];
        int len_tab  [12];
        int d, idx, lang, len, ab, kind;
        strs[0] = "Example Board";
        strs[1] = "ACME Systems";
        lang_tab = '{16'h0409, 16'h0407, 16'h040C, 16'h1234};
        len_tab  = '{0, 1, 2, 6, 8, 16, 24, 26, 28, 64, 255, 65535};
        for (int i = 0; i < 2; i++) begin
            reset_n[i] = 1'b0; req_valid[i] = 1'b0; req_index[i] = '0;
            req_langid[i] = '0; req_length[i] = '0; abort[i] = 1'b0; out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", req_ready[i], 1'b0);
            check_eq("rst_valid", out_valid[i], 1'b0);
            check_eq("rst_flags", {out_last[i], out_zlp[i], done[i], stall[i]}, 4'b0);
            check_eq("rst_data", out_data[i], 8'h00);
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst0", req_ready[0], 1'b1);
        check_eq("ready_after_rst1", req_ready[1], 1'b1);

        xfer(0, 0, 16'h0409, 255, 100, -1);
        xfer(0, 1, 16'h0409, 255, 100, -1);
        xfer(0, 2, 16'h0409, 255, 100, -1);
        xfer(0, 1, 16'h0409, 6, 100, -1);
        xfer(0, 1, 16'h0409, 0, 100, -1);
        xfer(0, 3, 16'h0409, 255, 100, -1);
        xfer(0, 1, 16'h0407, 255, 100, -1);
        xfer(0, 0, 16'h0407, 255, 100, -1);
        xfer(1, 0, 16'h0409, 64, 100, -1);
        xfer(1, 0, 16'h0409, 8, 100, -1);
        xfer(1, 2, 16'h0409, 255, 100, -1);
        xfer(1, 1, 16'h040C, 255, 100, -1);
        xfer(1, 1, 16'h0407, 24, 50, -1);
        xfer(0, 1, 16'h0409, 255, 100, 5);
        xfer(0, 1, 16'h0409, 255, 40, -1);

        for (int it = 0; it < 40; it++) begin
            d    = $urandom_range(1);
            idx  = $urandom_range(3);
            lang = lang_tab[$urandom_range(3)];
            len  = ($urandom_range(4) == 0) ? $urandom_range(300) : len_tab[$urandom_range(11)];
            build_exp(d, idx, lang, len, kind);
            ab = (kind == 0 && $urandom_range(5) == 0) ? $urandom_range(exp_q.size() - 1) : -1;
            xfer(d, idx, lang, len, $urandom_range(30, 100), ab);
        end

        req_valid[0] = 1'b1; req_index[0] = 8'd1; req_langid[0] = 16'h0409; req_length[0] = 16'd255;
        @(negedge clk);
        req_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("mid_valid", out_valid[0], 1'b1);
        reset_n[0] = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", out_valid[0], 1'b0);
        check_eq("midrst_ready", req_ready[0], 1'b0);
        check_eq("midrst_flags", {out_last[0], out_zlp[0], done[0], stall[0]}, 4'b0);
        check_eq("midrst_data", out_data[0], 8'h00);
        reset_n[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready_back", req_ready[0], 1'b1);
        check_eq("midrst_no_done", done[0], 1'b0);
        xfer(0, 2, 16'h0409, 255, 100, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
